// File: rtl/rv_pkg.sv
// Shared register-file constants for the ID stage: data width, register count
// and the index of the hardwired zero register.
package rv_pkg;

   localparam int XLEN      = 32;
   localparam int NREGS     = 32;
   localparam int REG_IDX_W = 5;

   localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]      reg_data_t;
   typedef logic [NREGS-1:0]     reg_mask_t;

   // One-hot mask for a register index; index 0 yields an empty mask
   // because x0 can never be the target of a write or a load.
   function automatic reg_mask_t idx_onehot(input reg_idx_t idx);
      reg_mask_t m;
      m = '0;
      if (idx != REG_ZERO) m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Load-use scoreboard: tracks registers with an outstanding load and raises a
// stall when a source operand is pending. Optional macro: ID_REG_BANK_BYPASS_EN.
module reg_scoreboard
   import rv_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] rs1,
   input  logic [REG_IDX_W-1:0] rs2,
   input  logic                 reg_write,
   input  logic [REG_IDX_W-1:0] rd_wb,
   input  logic                 issue_load,
   input  logic [REG_IDX_W-1:0] rd_issue,
   output logic                 stall,
   output logic [NREGS-1:0]     pending_mask
);

   logic [NREGS-1:0] pending_q;
   logic [NREGS-1:0] pending_d;
   logic             wb_hit1;
   logic             wb_hit2;
   logic             busy1;
   logic             busy2;

   always_comb begin
      wb_hit1 = 1'b0;
      wb_hit2 = 1'b0;
`ifdef ID_REG_BANK_BYPASS_EN
      // The write landing this cycle is forwarded, so its pending bit is moot.
      wb_hit1 = reg_write && (rd_wb == rs1);
      wb_hit2 = reg_write && (rd_wb == rs2);
`else
      wb_hit1 = 1'b0;
      wb_hit2 = 1'b0;
`endif
      busy1 = (rs1 != REG_ZERO) && pending_q[rs1] && !wb_hit1;
      busy2 = (rs2 != REG_ZERO) && pending_q[rs2] && !wb_hit2;
      stall = !reset && (busy1 || busy2);
   end

   // Clear first, then set, so a new load to the same index supersedes the
   // completing one.
   always_comb begin
      pending_d = pending_q;
      if (reg_write) pending_d = pending_d & ~idx_onehot(rd_wb);
      if (issue_load && !stall) pending_d = pending_d | idx_onehot(rd_issue);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending_mask = pending_q;

endmodule

// File: rtl/id_reg_bank.sv
// ID-stage register bank: 32x32 registers with x0 hardwired to zero, two
// combinational read ports, and a load-use scoreboard. Optional macro: ID_REG_BANK_BYPASS_EN.
module id_reg_bank
   import rv_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] RS1_ID,
   input  logic [REG_IDX_W-1:0] RS2_ID,
   output logic [XLEN-1:0]      READ_DATA1_ID,
   output logic [XLEN-1:0]      READ_DATA2_ID,
   input  logic                 RegWrite_ID,
   input  logic [REG_IDX_W-1:0] RD_WB,
   input  logic [XLEN-1:0]      WRITE_DATA_WB_ID,
   input  logic                 ISSUE_LOAD_ID,
   input  logic [REG_IDX_W-1:0] RD_ISSUE_ID,
   output logic                 STALL_ID,
   output logic [NREGS-1:0]     PENDING_MASK
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_en;

   assign wr_en = RegWrite_ID && (RD_WB != REG_ZERO);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[RD_WB] <= WRITE_DATA_WB_ID;
      end
   end

   always_comb begin
      READ_DATA1_ID = '0;
      READ_DATA2_ID = '0;
      if (RS1_ID != REG_ZERO) READ_DATA1_ID = regs[RS1_ID];
      if (RS2_ID != REG_ZERO) READ_DATA2_ID = regs[RS2_ID];
`ifdef ID_REG_BANK_BYPASS_EN
      // Write-before-read: the WB value is visible in the same cycle.
      if (wr_en && (RD_WB == RS1_ID)) READ_DATA1_ID = WRITE_DATA_WB_ID;
      if (wr_en && (RD_WB == RS2_ID)) READ_DATA2_ID = WRITE_DATA_WB_ID;
`endif
   end

   reg_scoreboard u_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .rs1          (RS1_ID),
      .rs2          (RS2_ID),
      .reg_write    (RegWrite_ID),
      .rd_wb        (RD_WB),
      .issue_load   (ISSUE_LOAD_ID),
      .rd_issue     (RD_ISSUE_ID),
      .stall        (STALL_ID),
      .pending_mask (PENDING_MASK)
   );

endmodule

// File: doc/id_reg_bank.md
Name: id_reg_bank

Overview:
- Register bank in the ID stage; the receiving end of the write-back path driven by the WB stage (RegWrite_ID, RD_WB, WRITE_DATA_WB_ID).
- 32 x 32-bit registers, x0 hardwired to zero, two asynchronous read ports for ID.
- Contains a load-use scoreboard: ID marks a load destination as pending at issue; the WB write clears the mark. ID stalls while a source operand is pending.

Parameters:
- NREGS, 32, number of architectural registers; index width is 5.
- XLEN, 32, register data width.

Ports:
- clk  input  1  pipeline clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- RS1_ID  input  5  source register 1 index from the decoded instruction.
- RS2_ID  input  5  source register 2 index.
- READ_DATA1_ID  output  32  value of RS1.
- READ_DATA2_ID  output  32  value of RS2.
- RegWrite_ID  input  1  write enable from WB.
- RD_WB  input  5  write destination from WB.
- WRITE_DATA_WB_ID  input  32  write data from WB.
- ISSUE_LOAD_ID  input  1  a load leaves ID this cycle; mark RD_ISSUE_ID pending.
- RD_ISSUE_ID  input  5  destination of the issuing load.
- STALL_ID  output  1  a source operand is pending; hold IF/ID and insert a bubble.
- PENDING_MASK  output  32  scoreboard state, bit i = register i pending (debug/forward unit).

Behaviour:
- Reset: asynchronous. Clears all registers to 0 and PENDING_MASK to 0. STALL_ID is 0 while reset is high. Reset mid-load discards all pending marks.
- Write: on the rising clk edge, write when RegWrite_ID=1 and RD_WB!=0. A write to x0 is ignored.
- Read:
  - Combinational, zero latency.
  - An index of 0 returns 0.
  - Read-during-write behaviour depends on the optional feature.
- Scoreboard set: on the rising edge, set bit RD_ISSUE_ID when ISSUE_LOAD_ID=1, RD_ISSUE_ID!=0 and STALL_ID=0. While stalled, ISSUE_LOAD_ID is ignored.
- Scoreboard clear: on the rising edge, clear bit RD_WB when RegWrite_ID=1.
- Simultaneous set and clear of the same index: set wins. The new load supersedes the completing one.
- STALL_ID (combinational): asserted when (RS1_ID!=0 and pending[RS1_ID] and not wb_hit1) or the same condition for RS2.
  - wb_hit1 = RegWrite_ID and RD_WB==RS1_ID, but only with bypass enabled. Without bypass, wb_hit is always 0.
  - wb_hit2 is defined the same way for RS2.
- Identical RS1/RS2 are handled independently, with identical results.
- Writes to a register that is not pending are legal (ALU results) and leave the scoreboard unchanged.
- No clocked outputs other than PENDING_MASK. Internal state is only the register array and the pending vector.

Optional Feature:
- Macro: ID_REG_BANK_BYPASS_EN.
- Defined:
  - A read of index r!=0 while RegWrite_ID=1 and RD_WB==r returns WRITE_DATA_WB_ID (write-before-read).
  - The pending bit of r is ignored for the stall decision that cycle.
- Undefined:
  - Reads return the stored (old) value.
  - STALL_ID stays asserted until the cycle after the write lands, which costs one extra bubble per load-use.

Decomposition:
- Shared package rv_pkg: XLEN, NREGS, REG_IDX_W=5, REG_ZERO=5'd0.
- Natural sub-module: reg_scoreboard. It holds the pending vector, the set/clear logic and the stall comparison.
- The register array and read muxes stay in id_reg_bank.

Test Plan:
- Reset with all registers preloaded by writes, then reset pulse asynchronous mid-cycle -> READ_DATA1_ID=0 for RS1=5, PENDING_MASK=0, STALL_ID=0 before the next edge.
- Write x0=0xDEADBEEF, then read RS1=0 -> READ_DATA1_ID=0.
- Write x7=0x12345678, read RS1=7 and RS2=7 in the next cycle -> both outputs 0x12345678.
- Bypass build, same cycle RegWrite_ID=1 RD_WB=9 data 0xA5A5A5A5 and RS2=9 -> READ_DATA2_ID=0xA5A5A5A5. Non-bypass build -> the old value is returned.
- Load-use sequence:
  - ISSUE_LOAD_ID with RD=3, next cycle RS1=3 -> STALL_ID=1, PENDING_MASK=0x8.
  - WB writes x3: bypass build releases the stall in that cycle; non-bypass build releases it one cycle later.
- Set/clear collision: PENDING bit 4 set, same edge has WB write RD=4 and ISSUE_LOAD_ID RD=4 -> PENDING_MASK bit 4 remains 1. ISSUE_LOAD_ID with RD=0 -> mask unchanged.
